// File: rtl/sprite_layer_mixer_if.sv
// Pixel-domain bundle between the sprite compositors and the layer mixer.
// Carries per-layer hit/colour, syncs, and the mixed video plus frame timing back out.
interface sprite_layer_mixer_if #(
    parameter int unsigned NUM_LAYERS = 4
) ();
    logic                       i_h_sync;
    logic                       i_v_sync;
    logic                       i_de;
    logic [NUM_LAYERS-1:0]      i_layer_hit;
    logic [NUM_LAYERS*24-1:0]   i_layer_rgb;
    logic [NUM_LAYERS-1:0]      i_layer_blink_en;
    logic [23:0]                i_bg_rgb;
    logic [7:0]                 o_red;
    logic [7:0]                 o_green;
    logic [7:0]                 o_blue;
    logic                       o_h_sync;
    logic                       o_v_sync;
    logic                       o_de;
    logic [7:0]                 o_frame_cnt;
    logic                       o_blink_phase;

    modport master (
        output i_h_sync, i_v_sync, i_de, i_layer_hit, i_layer_rgb, i_layer_blink_en, i_bg_rgb,
        input  o_red, o_green, o_blue, o_h_sync, o_v_sync, o_de, o_frame_cnt, o_blink_phase
    );

    modport slave (
        input  i_h_sync, i_v_sync, i_de, i_layer_hit, i_layer_rgb, i_layer_blink_en, i_bg_rgb,
        output o_red, o_green, o_blue, o_h_sync, o_v_sync, o_de, o_frame_cnt, o_blink_phase
    );
endinterface

// File: rtl/sprite_layer_mixer.sv
// Two-stage sprite layer priority mixer with matched sync delay.
// Also keeps the frame counter and blink phase, advanced on v_sync rising edges.
module sprite_layer_mixer #(
    parameter int unsigned NUM_LAYERS   = 4,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    sprite_layer_mixer_if.slave   vid_io
);
    localparam logic [7:0] BlinkLast = 8'(BLINK_FRAMES - 1);

    // Stage 1: registered inputs
    logic [NUM_LAYERS-1:0]    hit_q;
    logic [NUM_LAYERS*24-1:0] rgb_q;
    logic [NUM_LAYERS-1:0]    blink_en_q;
    logic [23:0]              bg_q;
    logic                     hs1_q, vs1_q, de1_q;
    // Stage 2: mixed pixel and delayed syncs
    logic [23:0]              rgb2_q;
    logic                     hs2_q, vs2_q, de2_q;
    // Frame timing
    logic                     vs_prev_q;
    logic [7:0]               frame_q, frame_d;
    logic [7:0]               blink_cnt_q, blink_cnt_d;
    logic                     phase_q, phase_d;

    logic [NUM_LAYERS-1:0]    visible;
    logic [23:0]              mix_rgb;
    logic                     frame_edge;

    assign visible    = hit_q & ~(blink_en_q & {NUM_LAYERS{phase_q}});
    assign frame_edge = vs1_q & ~vs_prev_q;

    // Hit-gated priority chain so unqualified (possibly X) layer data never reaches the output.
    always_comb begin
        mix_rgb = bg_q;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (visible[k]) begin
                mix_rgb = rgb_q[k*24 +: 24];
            end
        end
        if (!de1_q) begin
            mix_rgb = '0;
        end
    end

    always_comb begin
        frame_d     = frame_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (frame_edge) begin
            frame_d = frame_q + 8'd1;
            if (blink_cnt_q == BlinkLast) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hit_q       <= '0;
            rgb_q       <= '0;
            blink_en_q  <= '0;
            bg_q        <= '0;
            hs1_q       <= 1'b0;
            vs1_q       <= 1'b0;
            de1_q       <= 1'b0;
            rgb2_q      <= '0;
            hs2_q       <= 1'b0;
            vs2_q       <= 1'b0;
            de2_q       <= 1'b0;
            vs_prev_q   <= 1'b0;
            frame_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            hit_q       <= vid_io.i_layer_hit;
            rgb_q       <= vid_io.i_layer_rgb;
            blink_en_q  <= vid_io.i_layer_blink_en;
            bg_q        <= vid_io.i_bg_rgb;
            hs1_q       <= vid_io.i_h_sync;
            vs1_q       <= vid_io.i_v_sync;
            de1_q       <= vid_io.i_de;
            rgb2_q      <= mix_rgb;
            hs2_q       <= hs1_q;
            vs2_q       <= vs1_q;
            de2_q       <= de1_q;
            vs_prev_q   <= vs1_q;
            frame_q     <= frame_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign vid_io.o_red         = rgb2_q[23:16];
    assign vid_io.o_green       = rgb2_q[15:8];
    assign vid_io.o_blue        = rgb2_q[7:0];
    assign vid_io.o_h_sync      = hs2_q;
    assign vid_io.o_v_sync      = vs2_q;
    assign vid_io.o_de          = de2_q;
    assign vid_io.o_frame_cnt   = frame_q;
    assign vid_io.o_blink_phase = phase_q;
endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Scoreboard bench for sprite_layer_mixer: the driver queues expected outputs with their due
// cycle, and a negedge monitor pops and compares them.
module tb_sprite_layer_mixer;
    logic i_clk;
    logic i_rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;

    typedef struct {
        int          due;
        bit          chk_vid;
        logic [26:0] vid;   // {rgb, h_sync, v_sync, de}
        bit          chk_cnt;
        logic [8:0]  cnt;   // {frame_cnt, blink_phase}
        string       name;
    } exp_t;

    exp_t sb[$];

    sprite_layer_mixer_if #(.NUM_LAYERS(4)) vif ();

    sprite_layer_mixer #(
        .NUM_LAYERS  (4),
        .BLINK_FRAMES(2)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .vid_io (vif.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        logic [26:0] got_vid;
        logic [8:0]  got_cnt;
        exp_t        e;
        got_vid = {vif.o_red, vif.o_green, vif.o_blue, vif.o_h_sync, vif.o_v_sync, vif.o_de};
        got_cnt = {vif.o_frame_cnt, vif.o_blink_phase};
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_tests = n_tests + 1;
            if (e.due != cyc) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.due);
            end else if (e.chk_vid && (got_vid !== e.vid || $isunknown(got_vid))) begin
                n_fail = n_fail + 1;
                $display("FAIL %s @%0d: rgb/hs/vs/de got %h/%b%b%b required %h/%b%b%b",
                         e.name, cyc, got_vid[26:3], got_vid[2], got_vid[1], got_vid[0],
                         e.vid[26:3], e.vid[2], e.vid[1], e.vid[0]);
            end else if (e.chk_cnt && got_cnt !== e.cnt) begin
                n_fail = n_fail + 1;
                $display("FAIL %s @%0d: frame/phase got %0d/%b required %0d/%b",
                         e.name, cyc, got_cnt[8:1], got_cnt[0], e.cnt[8:1], e.cnt[0]);
            end
        end
    end

    task automatic push_vid(input int due, input logic [23:0] rgb, input bit hs, input bit vs,
                            input bit de, input string name);
        exp_t e;
        e.due = due; e.chk_vid = 1'b1; e.vid = {rgb, hs, vs, de};
        e.chk_cnt = 1'b0; e.cnt = '0; e.name = name;
        sb.push_back(e);
    endtask

    task automatic push_zero(input int due, input string name);
        exp_t e;
        e.due = due; e.chk_vid = 1'b1; e.vid = '0;
        e.chk_cnt = 1'b1; e.cnt = '0; e.name = name;
        sb.push_back(e);
    endtask

    // Called at a negedge with no edge in flight; expects the current counter state.
    task automatic chk_cnt(input logic [7:0] frame, input bit phase, input string name);
        exp_t e;
        e.due = cyc + 1; e.chk_vid = 1'b0; e.vid = '0;
        e.chk_cnt = 1'b1; e.cnt = {frame, phase}; e.name = name;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs at a negedge; the mixed pixel is due two cycles later.
    task automatic drive(input bit rst_n, input bit hs, input bit vs, input bit de,
                         input logic [3:0] hit, input logic [95:0] rgb, input logic [3:0] ben,
                         input logic [23:0] bg, input logic [23:0] exp_rgb, input string name);
        i_rst_n              = rst_n;
        vif.i_h_sync         = hs;
        vif.i_v_sync         = vs;
        vif.i_de             = de;
        vif.i_layer_hit      = hit;
        vif.i_layer_rgb      = rgb;
        vif.i_layer_blink_en = ben;
        vif.i_bg_rgb         = bg;
        if (rst_n) begin
            push_vid(cyc + 2, exp_rgb, hs, vs, de, name);
        end else begin
            while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
            push_zero(cyc + 1, {name, "_next"});
            push_zero(cyc + 2, {name, "_stage"});
        end
        @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 4'h0, 96'h0, 4'h0, 24'h0, 24'h0, "idle");
    endtask

    initial begin
        logic [95:0] lrgb;
        logic [95:0] xrgb;
        logic [23:0] blink_exp [4];
        logic [7:0]  blink_frame [4];
        bit          blink_ph [4];
        n_tests = 0;
        n_fail  = 0;
        i_rst_n = 1'b0;
        vif.i_h_sync = 1'b0; vif.i_v_sync = 1'b0; vif.i_de = 1'b0;
        vif.i_layer_hit = '0; vif.i_layer_rgb = '0; vif.i_layer_blink_en = '0; vif.i_bg_rgb = '0;
        @(negedge i_clk);
        repeat (2) drive(0, 0, 0, 0, 4'h0, 96'h0, 4'h0, 24'h0, 24'h0, "reset");

        // Priority: layer1 over layer3, then layer3 alone, then background
        lrgb = {24'h00FF00, 24'h000000, 24'hFF0000, 24'h000000};
        drive(1, 0, 0, 1, 4'b1010, lrgb, 4'h0, 24'h202020, 24'hFF0000, "prio_l1");
        drive(1, 0, 0, 1, 4'b1000, lrgb, 4'h0, 24'h202020, 24'h00FF00, "prio_l3");
        drive(1, 0, 0, 1, 4'b0000, lrgb, 4'h0, 24'h202020, 24'h202020, "prio_bg");

        // Blanking and X-safety
        drive(1, 0, 0, 0, 4'b0001, {72'h0, 24'hFFFFFF}, 4'h0, 24'h202020, 24'h0, "blank");
        xrgb = {96{1'bx}};
        drive(1, 0, 0, 1, 4'b0000, xrgb, 4'h0, 24'h123456, 24'h123456, "xsafe_bg");
        xrgb[23:0] = 24'hAABBCC;
        drive(1, 0, 0, 1, 4'b0001, xrgb, 4'h0, 24'h123456, 24'hAABBCC, "xsafe_l0");

        // Sync alignment: single-cycle pulses on h_sync, v_sync, de
        idle(2);
        drive(1, 1, 0, 0, 4'h0, 96'h0, 4'h0, 24'h0, 24'h0, "hs_pulse");
        idle(2);
        drive(1, 0, 1, 0, 4'h0, 96'h0, 4'h0, 24'h0, 24'h0, "vs_pulse");
        idle(2);
        drive(1, 0, 0, 1, 4'h0, 96'h0, 4'h0, 24'h0, 24'h0, "de_pulse");
        idle(2);
        chk_cnt(8'd1, 1'b0, "frame_after_sync");
        idle(1);

        // Mid-frame reset during active video
        lrgb = {72'h0, 24'h112233};
        drive(1, 0, 0, 1, 4'b0001, lrgb, 4'h0, 24'h0, 24'h112233, "pre_rst_a");
        drive(1, 0, 0, 1, 4'b0001, lrgb, 4'h0, 24'h0, 24'h112233, "pre_rst_b");
        drive(0, 0, 0, 1, 4'b0001, lrgb, 4'h0, 24'h0, 24'h0, "mid_rst");
        lrgb = {72'h0, 24'h445566};
        drive(1, 0, 0, 1, 4'b0001, lrgb, 4'h0, 24'h0, 24'h445566, "post_rst_a");
        drive(1, 0, 0, 1, 4'b0011, lrgb, 4'h0, 24'h0, 24'h445566, "post_rst_b");
        idle(2);

        // Blink with BLINK_FRAMES=2: layer0 blinks, layer1 blue underneath
        lrgb = {48'h0, 24'h0000FF, 24'hFF00FF};
        blink_frame[0] = 8'd1; blink_frame[1] = 8'd2; blink_frame[2] = 8'd3; blink_frame[3] = 8'd4;
        blink_ph[0] = 1'b0; blink_ph[1] = 1'b1; blink_ph[2] = 1'b1; blink_ph[3] = 1'b0;
        blink_exp[0] = 24'hFF00FF; blink_exp[1] = 24'h0000FF;
        blink_exp[2] = 24'h0000FF; blink_exp[3] = 24'hFF00FF;
        for (int p = 0; p < 4; p++) begin
            drive(1, 0, 1, 0, 4'b0011, lrgb, 4'b0001, 24'h0, 24'h0, "blink_vs");
            idle(2);
            chk_cnt(blink_frame[p], blink_ph[p], "blink_cnt");
            drive(1, 0, 0, 1, 4'b0011, lrgb, 4'b0001, 24'h0, blink_exp[p], "blink_pix");
        end
        idle(2);

        // Frame counter wrap after 256 frames from reset
        drive(0, 0, 0, 0, 4'h0, 96'h0, 4'h0, 24'h0, 24'h0, "wrap_rst");
        idle(2);
        for (int i = 0; i < 256; i++) begin
            drive(1, 0, 1, 0, 4'h0, 96'h0, 4'h0, 24'h0, 24'h0, "wrap_vs");
            drive(1, 0, 0, 0, 4'h0, 96'h0, 4'h0, 24'h0, 24'h0, "wrap_low");
        end
        idle(2);
        chk_cnt(8'd0, 1'b0, "frame_wrap");
        idle(1);

        // v_sync held high counts once
        for (int i = 0; i < 100; i++)
            drive(1, 0, 1, 0, 4'h0, 96'h0, 4'h0, 24'h0, 24'h0, "held_vs");
        chk_cnt(8'd1, 1'b0, "held_high");
        idle(2);
        chk_cnt(8'd1, 1'b0, "held_release");
        idle(1);
        drive(1, 0, 1, 0, 4'h0, 96'h0, 4'h0, 24'h0, 24'h0, "after_hold_vs");
        idle(2);
        chk_cnt(8'd2, 1'b1, "after_hold");
        idle(1);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge i_clk);
        if (sb.size() > 0) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_layer_mixer.md
Name: sprite_layer_mixer

Overview:
- Pixel-domain mixer directly downstream of the sprite compositors (meter, player, enemy, HUD layers).
- Takes each layer's per-pixel RGB and hit flag, selects the highest-priority visible layer or the background, and registers the result for the video output.
- Delays h_sync/v_sync/de to match the pixel pipeline.
- Owns the frame counter and the per-layer blink timing, updated on v_sync edges.

Parameters:
- NUM_LAYERS, 4, number of sprite layers; index 0 = highest priority.
- BLINK_FRAMES, 16, frames per blink half-period; legal range 1..255.

Ports:
- i_clk  input  1  pixel clock.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_h_sync  input  1  horizontal sync, aligned with layer inputs.
- i_v_sync  input  1  vertical sync, active-high; rising edge = frame start.
- i_de  input  1  display enable, aligned with layer inputs.
- i_layer_hit  input  NUM_LAYERS  per-layer sprite hit (compositor o_sprite_hit).
- i_layer_rgb  input  NUM_LAYERS*24  per layer {red,green,blue}; layer k at bits [24k+23:24k].
- i_layer_blink_en  input  NUM_LAYERS  layer blinks when 1.
- i_bg_rgb  input  24  background {red,green,blue}.
- o_red  output  8  mixed red.
- o_green  output  8  mixed green.
- o_blue  output  8  mixed blue.
- o_h_sync  output  1  delayed h_sync.
- o_v_sync  output  1  delayed v_sync.
- o_de  output  1  delayed de.
- o_frame_cnt  output  8  frames since reset, wraps 255->0.
- o_blink_phase  output  1  current blink phase; 1 = blinking layers hidden.

Behaviour:
- Clocking: single clock. All state updates on the rising edge of i_clk.
- Reset: when i_rst_n=0 at a clock edge, the following clear to 0:
  - all pipeline registers
  - o_red, o_green, o_blue, o_h_sync, o_v_sync, o_de
  - o_frame_cnt, the internal blink counter, o_blink_phase
  - the v_sync history register
- Reset mid-frame: outputs read 0 on the cycle after the reset edge. Valid data reappears 2 cycles after release.
- Pipeline, fixed latency 2 cycles for every output video signal:
  - Stage 1 registers the inputs: hit, rgb, blink_en, bg, h_sync, v_sync, de.
  - Stage 2 registers the mixed colour and the delayed syncs/de.
- Visibility: layer k is visible when its stage-1 hit=1 AND NOT (blink_en[k]=1 AND o_blink_phase=1).
- Selection: the lowest-index visible layer supplies the RGB. If no layer is visible, the output is stage-1 bg.
- X-safety:
  - RGB of non-selected or non-hit layers is never observable at the outputs; compositors drive X when not hit.
  - The mux must be hit-gated (AND-OR or priority if-chain), never index arithmetic on unqualified data.
- Blanking: when stage-1 de=0, stage-2 RGB = 0, regardless of hits.
- Frame edge detection:
  - Edge = stage-1 v_sync=1 AND previous stage-1 v_sync=0.
  - On edge, o_frame_cnt increments modulo 256.
- Blink counter: counts 0..BLINK_FRAMES-1 on each edge. On an edge while at BLINK_FRAMES-1 it goes to 0 and o_blink_phase toggles.
  - BLINK_FRAMES=1 toggles the phase every frame.
- Phase timing: o_frame_cnt and o_blink_phase change on the same clock as the edge is detected. The new phase governs visibility from the next clock; this falls in vertical blanking.
- v_sync held high: counts once only. Counting restarts only after v_sync goes low for at least one cycle.
- Simultaneous events: reset has priority over the edge increment.
- Width rules: o_frame_cnt wraps without saturation. The blink counter is 8 bits.

Test Plan:
- Priority: NUM_LAYERS=4; hit=4'b1010, layer1=FF0000, layer3=00FF00, de=1 -> RGB FF/00/00 exactly 2 clocks later. Then hit=4'b1000 -> 00/FF/00. Then hit=0, bg=202020 -> 20/20/20.
- Blanking/X-safety: de=0, hit=4'b0001, layer0=FFFFFF -> RGB 00/00/00. Then de=1, hit=0, all layer rgb driven X -> RGB equals bg with no X bits.
- Sync alignment: pulse i_h_sync for 1 cycle at cycle 10 -> o_h_sync high only at cycle 12. v_sync and de behave identically.
- Blink: BLINK_FRAMES=2, layer0 blink_en=1 and hit=1, layer1 hit=1 with rgb 0000FF. Apply 4 v_sync pulses:
  - o_frame_cnt=1,2,3,4.
  - o_blink_phase=0,1,1,0 after pulses 1-4.
  - Output is layer1 blue while phase=1, layer0 otherwise.
- Frame wrap and held v_sync: apply 256 pulses -> o_frame_cnt=0. Hold v_sync high for 100 cycles -> increments exactly once.
- Mid-frame reset: drive active video, assert i_rst_n=0 for 1 cycle -> all outputs, o_frame_cnt and o_blink_phase = 0 next cycle. Valid mixed pixels resume 2 cycles after release.
